// File: rtl/byte_lane_sequencer_if.sv
// Bundles the core request/response channel and the byte-wide memory channel
// of byte_lane_sequencer. The slave modport is the sequencer's view, the
// master modport is the view of whatever drives the core and memory sides.
interface byte_lane_sequencer_if #(
    parameter int OFFSET_SIZE = 2,
    parameter int VECTOR_SIZE = 4,
    parameter int ADDR_WIDTH  = 30
);
    // Core side
    logic                              req_valid;
    logic                              req_ready;
    logic                              req_we;
    logic [ADDR_WIDTH-1:0]             req_addr;
    logic [VECTOR_SIZE-1:0]            req_vector;
    logic [8*VECTOR_SIZE-1:0]          req_wdata;
    logic                              resp_valid;
    logic                              resp_err;
    logic [8*VECTOR_SIZE-1:0]          resp_rdata;

    // Byte-wide memory side
    logic                              mem_req;
    logic                              mem_we;
    logic [ADDR_WIDTH+OFFSET_SIZE-1:0] mem_addr;
    logic [7:0]                        mem_wdata;
    logic                              mem_ack;
    logic [7:0]                        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_vector, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_vector, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/byte_lane_sequencer.sv
// Breaks one word load/store, qualified by a contiguous byte-enable vector,
// into single-byte transactions on a byte-wide memory port, then returns the
// assembled (lane-aligned) load word or a store completion. Non-contiguous or
// empty vectors complete immediately with an error and touch no memory.
module byte_lane_sequencer #(
    parameter int OFFSET_SIZE = 2,
    parameter int VECTOR_SIZE = 4,
    parameter int ADDR_WIDTH  = 30
) (
    input logic                 clk,
    input logic                 rst,
    byte_lane_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_we;
    logic [8*VECTOR_SIZE-1:0] r_wdata;
    logic [8*VECTOR_SIZE-1:0] r_rdata;
    logic [OFFSET_SIZE-1:0]   r_cur;
    logic [OFFSET_SIZE-1:0]   r_end;
    logic                     r_err;

    logic                     w_legal;
    logic [OFFSET_SIZE-1:0]   w_begin;
    logic [OFFSET_SIZE-1:0]   w_end;
    logic                     w_last;

    // Decode the byte-enable vector into first/last lane; only contiguous runs are legal
    always_comb begin
        w_legal = 1'b1;
        w_begin = '0;
        w_end   = '0;
        case (bus.req_vector)
            4'b0001: begin w_begin = 2'd0; w_end = 2'd0; end
            4'b0011: begin w_begin = 2'd0; w_end = 2'd1; end
            4'b0111: begin w_begin = 2'd0; w_end = 2'd2; end
            4'b1111: begin w_begin = 2'd0; w_end = 2'd3; end
            4'b1000: begin w_begin = 2'd3; w_end = 2'd3; end
            4'b1100: begin w_begin = 2'd2; w_end = 2'd3; end
            4'b1110: begin w_begin = 2'd1; w_end = 2'd3; end
            4'b0110: begin w_begin = 2'd1; w_end = 2'd2; end
            4'b0100: begin w_begin = 2'd2; w_end = 2'd2; end
            4'b0010: begin w_begin = 2'd1; w_end = 2'd1; end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_last = (r_cur == r_end);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, walk lanes in ACCESS, one-cycle RESP
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_next_state = w_legal ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ack && w_last) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, lane cursor and read-data assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cur   <= '0;
            r_end   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr  <= bus.req_addr;
                        r_we    <= bus.req_we;
                        r_wdata <= bus.req_wdata;
                        r_rdata <= '0;
                        r_cur   <= w_begin;
                        r_end   <= w_end;
                        r_err   <= ~w_legal;
                    end
                end
                S_ACCESS: begin
                    if (bus.mem_ack) begin
                        if (!r_we) begin
                            r_rdata[8*r_cur +: 8] <= bus.mem_rdata;
                        end
                        // The cursor stops on the last lane; end >= begin so it never wraps
                        if (!w_last) begin
                            r_cur <= r_cur + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    r_err <= 1'b0;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from state and registers only; nothing flows from mem_ack to mem_req
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
            end
            S_ACCESS: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_addr  = {r_addr, r_cur};
                bus.mem_wdata = r_wdata[8*r_cur +: 8];
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = r_err;
                bus.resp_rdata = r_we ? '0 : r_rdata;
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_byte_lane_sequencer.sv
// Scoreboard bench for byte_lane_sequencer: stimulus predicts the byte
// transactions and the response from a word/byte memory model and queues them;
// independent monitors compare whatever the DUT presents.
module tb_byte_lane_sequencer;

    localparam int OS = 2;
    localparam int VS = 4;
    localparam int AW = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_lane_sequencer_if #(.OFFSET_SIZE(OS), .VECTOR_SIZE(VS), .ADDR_WIDTH(AW)) bus ();

    byte_lane_sequencer #(
        .OFFSET_SIZE(OS),
        .VECTOR_SIZE(VS),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } mem_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;   // expected cycle stamp, -1 when timing is not checked
    } resp_exp_t;

    mem_exp_t  exp_mem[$];
    resp_exp_t exp_resp[$];
    mem_exp_t  mon_me;
    resp_exp_t mon_re;

    logic [7:0] model_mem[logic [31:0]];
    logic [7:0] phys_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wait_left = 0;
    bit ack_random = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] model_get(logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] phys_get(logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return init_byte(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic preset(input logic [31:0] a, input logic [7:0] d);
        model_mem[a] = d;
        phys_mem[a]  = d;
    endtask

    // Memory responder: decides ack and read byte for each cycle
    always @(posedge clk) begin
        #1;
        if (bus.mem_req) begin
            if (wait_left > 0) begin
                bus.mem_ack = 1'b0;
                wait_left--;
            end else begin
                bus.mem_ack = ack_random ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bus.mem_rdata = phys_get(bus.mem_addr);
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
        end
    end

    // Monitor: compares byte transactions and responses against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_req with nothing pending", {31'd0, bus.mem_req}, 32'd0);
                end else if (bus.mem_ack) begin
                    mon_me = exp_mem.pop_front();
                    chk("mem_addr", bus.mem_addr, mon_me.addr);
                    chk("mem_we", {31'd0, bus.mem_we}, {31'd0, mon_me.we});
                    if (mon_me.we) chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, mon_me.wdata});
                    if (bus.mem_we) phys_mem[bus.mem_addr] = bus.mem_wdata;
                end
            end
            if (bus.resp_valid) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_valid with nothing pending", {31'd0, bus.resp_valid}, 32'd0);
                end else begin
                    mon_re = exp_resp.pop_front();
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, mon_re.err});
                    chk("resp_rdata", bus.resp_rdata, mon_re.rdata);
                    if (mon_re.cyc >= 0) chk("resp_latency", cyc, mon_re.cyc);
                end
            end
        end
    end

    // Issue one request; expectations come from the contiguous-run rule and the model memory
    task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [3:0] vec,
                         input logic [31:0] wd, input int waits, input bit timed);
        int lo, hi, n;
        bit legal;
        resp_exp_t re;
        mem_exp_t me;
        logic [31:0] ba;
        lo = -1;
        hi = -1;
        for (int i = 0; i < 4; i++) begin
            if (vec[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        legal = (lo >= 0) && (int'(vec) == ((1 << (hi + 1)) - (1 << lo)));
        re.err   = !legal;
        re.rdata = '0;

        @(negedge clk);
        n = 0;
        while (!bus.req_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("req_ready timeout", {31'd0, bus.req_ready}, 32'd1);
                return;
            end
        end
        wait_left      = waits;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_vector = vec;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        if (legal) begin
            for (int i = lo; i <= hi; i++) begin
                ba       = {addr, 2'(i)};
                me.addr  = ba;
                me.we    = we;
                me.wdata = wd[8*i +: 8];
                exp_mem.push_back(me);
                if (we) model_mem[ba] = wd[8*i +: 8];
                else    re.rdata[8*i +: 8] = model_get(ba);
            end
        end
        re.cyc = timed ? (cyc + (legal ? (hi - lo + 1) + waits : 0)) : -1;
        exp_resp.push_back(re);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || exp_mem.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain responses", exp_resp.size(), 0);
        chk("drain byte transactions", exp_mem.size(), 0);
    endtask

    initial begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_vector = 4'b1111;
        bus.req_wdata  = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;

        // Reset held with a request pending
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post-rst mem_req", {31'd0, bus.mem_req}, 32'd0);

        // Full-word load with zero-wait memory
        ack_random = 1'b0;
        preset(32'h40, 8'hA1);
        preset(32'h41, 8'hB2);
        preset(32'h42, 8'hC3);
        preset(32'h43, 8'hD4);
        issue(1'b0, 30'h10, 4'b1111, 32'h0, 0, 1'b1);
        drain();

        // Two-lane store, first byte waits two cycles
        issue(1'b1, 30'h20, 4'b0110, 32'h11223344, 2, 1'b1);
        drain();

        // Single top-lane load
        preset(32'hC3, 8'h7F);
        issue(1'b0, 30'h30, 4'b1000, 32'h0, 0, 1'b1);
        drain();

        // Illegal vectors
        issue(1'b0, 30'h31, 4'b0101, 32'h0, 0, 1'b1);
        issue(1'b1, 30'h32, 4'b0000, 32'hFFFFFFFF, 0, 1'b1);
        drain();

        // Reset during the second byte of a full-word load
        issue(1'b0, 30'h50, 4'b1111, 32'h0, 0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_mem.delete();
        exp_resp.delete();
        @(negedge clk);
        chk("abort req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("abort resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("abort mem_addr", bus.mem_addr, 32'd0);
        repeat (3) @(negedge clk);
        issue(1'b0, 30'h50, 4'b1111, 32'h0, 0, 1'b1);
        drain();

        // Randomized mix over a small address window to exercise read-after-write
        for (int k = 0; k < 200; k++) begin
            ack_random = ($urandom_range(0, 1) == 1);
            issue(1'($urandom_range(0, 1)), 30'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  32'($urandom), 0, !ack_random);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_lane_sequencer.md
# byte_lane_sequencer

Sequences one RISC-V load/store word request, qualified by a 4-bit byte-enable vector, into a series of single-byte transactions on the byte-wide cached-memory port. The vector is decoded internally into begin and end byte offsets. The block issues one byte per memory handshake from the begin offset to the end offset, then assembles and returns the read word. It sits between the core's data-memory interface and the cache controller's byte port.

## Interface
- OFFSET_SIZE, 2, byte-offset width within a word
- VECTOR_SIZE, 4, byte-enable vector width (bytes per word)
- ADDR_WIDTH, 30, word-address width; the byte address is ADDR_WIDTH+OFFSET_SIZE bits

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  word address
- req_vector  in  VECTOR_SIZE  byte-enable vector; bit i = byte lane i
- req_wdata  in  8*VECTOR_SIZE  store data, lane-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  illegal vector, qualified by resp_valid
- resp_rdata  out  8*VECTOR_SIZE  load data, lane-aligned; unrequested lanes 0
- mem_req  out  1  byte transaction request
- mem_we  out  1  byte write
- mem_addr  out  ADDR_WIDTH+OFFSET_SIZE  {word addr, current offset}
- mem_wdata  out  8  store byte of the current lane
- mem_ack  in  1  memory accepts this cycle; mem_rdata valid same cycle
- mem_rdata  in  8  read byte

## Operation
- Legal vectors and their {begin,end} offsets:
  - 0001→{0,0}, 0011→{0,1}, 0111→{0,2}, 1111→{0,3}
  - 1000→{3,3}, 1100→{2,3}, 1110→{1,3}
  - 0110→{1,2}, 0100→{2,2}, 0010→{1,1}
- Every other vector, including 0000 and non-contiguous patterns such as 0101, is illegal.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, we, wdata and offsets, and clear the rdata register.
  - Legal vector: cur←begin, go to ACCESS.
  - Illegal vector: set the err flag, go to RESP. No memory access is made.
- ACCESS:
  - Drive mem_req=1, mem_we=latched we, mem_addr={addr,cur}, mem_wdata=wdata[8*cur+:8].
  - Outputs hold stable until mem_ack.
  - On mem_ack for a load, write mem_rdata into rdata[8*cur+:8].
  - If cur==end, go to RESP; else cur←cur+1.
- RESP:
  - resp_valid=1, resp_err=err flag, resp_rdata=rdata register.
  - For stores, resp_rdata=0.
  - Next cycle: go to IDLE and clear the err flag.
- req_ready=0 in ACCESS and RESP. A new request is accepted only in IDLE; no back-to-back overlap.
- cur never wraps, because end ≥ begin for all legal vectors.
- mem_ack outside ACCESS is ignored.

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - mem_req, mem_we, resp_valid, resp_err = 0.
  - mem_addr, mem_wdata, resp_rdata, cur = 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. The in-flight byte is abandoned and no response is issued.
- Acceptance at edge T0. First mem_req is high in cycle T0+1.
- With N bytes and zero-wait ack, resp_valid is high in cycle T0+N+1; the next request can be accepted at T0+N+2.
- Each wait cycle (mem_ack=0) adds one cycle.
- Illegal vector: resp_valid in cycle T0+1 with resp_err=1.
- Outputs are registered or decoded from state only; there is no combinational path from mem_ack to mem_req.

## Test plan
- Reset asserted with req_valid=1 → no request accepted; req_ready=1 and all other outputs 0 after release.
- Load, addr=0x10, vector=1111, mem_ack held 1, memory returns 0xA1,0xB2,0xC3,0xD4 → mem_addr 0x40..0x43 on consecutive cycles; resp_rdata=0xD4C3B2A1 at T0+5.
- Store, vector=0110, wdata=0x11223344, ack delayed 2 cycles on the first byte → mem_wdata 0x33 @ addr+1, then 0x22 @ addr+2; resp_valid at T0+5, resp_rdata=0.
- Load, vector=1000, rdata 0x7F → exactly one mem_req at offset 3; resp_rdata=0x7F000000.
- Vector 0101 and 0000 → no mem_req; resp_valid=1 and resp_err=1 at T0+1.
- rst pulsed during the second byte of a 1111 load → no resp_valid; state IDLE; a fresh request afterwards completes normally.
